// File: rtl/alu_operand_pkg.sv
// Shared defaults, source-bus indices and the load priority encoder for the ALU operand register.
package alu_operand_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_NUM_SRC = 3;
  localparam int unsigned DEF_DEPTH   = 2;
  localparam int unsigned MAX_SRC     = 32;

  typedef enum int unsigned {
    SRC_DATA_BUS = 0,
    SRC_ADDR_LOW = 1,
    SRC_CONST    = 2
  } src_idx_e;

  // Lowest set bit wins; returns 0 when nothing is requested (caller qualifies with |load_en).
  function automatic int unsigned prio_sel(input logic [MAX_SRC-1:0] load_en);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_SRC; i++) begin
      if (load_en[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/operand_fifo.sv
// Small FIFO holding staged ALU operands; occupancy is tracked by count rather than pointer compare.
module operand_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
  assign full = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/alu_operand_register.sv
// ALU operand input register: priority source select, optional inversion, FIFO staging and
// a holding register that retains the last consumed operand while the queue is empty.
module alu_operand_register
  import alu_operand_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*WIDTH-1:0]   src_data,
  input  logic [NUM_SRC-1:0]         load_en,
  input  logic                       invert_en,
  output logic [WIDTH-1:0]           operand_out,
  output logic                       operand_valid,
  input  logic                       operand_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  logic             load;
  logic             push;
  logic             pop;
  logic             drop;
  int unsigned      sel;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] hold_q;

  always_comb begin
    load = |load_en;
    sel  = prio_sel(MAX_SRC'(load_en));
    word = src_data[sel*WIDTH +: WIDTH];
    if (invert_en) word = ~word;
  end

  assign operand_valid = (count != '0);
  assign pop           = operand_valid & operand_ready;
  // A full queue still accepts a load when the head leaves in the same cycle.
  assign push          = load & (!full | pop);
  assign drop          = load & full & !pop;

  operand_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (word),
    .head  (head),
    .count (count),
    .full  (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      hold_q   <= '0;
    end else begin
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
      if (pop) hold_q <= head;
    end
  end

  assign operand_out = operand_valid ? head : hold_q;

endmodule

// File: tb/tb_alu_operand_register.sv
// Directed bench for alu_operand_register with a scoreboard queue checked by a pop monitor.
module tb_alu_operand_register;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] src_data = '0;
  logic [2:0]  load_en = '0;
  logic        invert_en = 1'b0;
  logic [7:0]  operand_out;
  logic        operand_valid;
  logic        operand_ready = 1'b0;
  logic [1:0]  count;
  logic        full;
  logic        overflow;
  logic        overflow_clr = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  alu_operand_register #(
    .WIDTH   (8),
    .NUM_SRC (3),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_data      (src_data),
    .load_en       (load_en),
    .invert_en     (invert_en),
    .operand_out   (operand_out),
    .operand_valid (operand_valid),
    .operand_ready (operand_ready),
    .count         (count),
    .full          (full),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens on the next rising edge whenever valid & ready are seen here.
  always @(negedge clk) begin
    if (rst_n && operand_valid && operand_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no pop", operand_out);
      end else begin
        check("pop_data", {24'h0, operand_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] en, input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic inv);
    load_en   = en;
    src_data  = {s2, s1, s0};
    invert_en = inv;
  endtask

  task automatic idle();
    load_en   = '0;
    invert_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},    32'(count), 0);
    check({tag, "_valid"},    32'(operand_valid), 0);
    check({tag, "_out"},      32'(operand_out), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_full"},     32'(full), 0);
  endtask

  initial begin
    #3;
    check_reset_state("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // Single load from source 1, then consume it
    load(3'b010, 8'h00, 8'h5A, 8'h00, 1'b0); exp_q.push_back(8'h5A);
    step(); idle();
    check("single_valid", 32'(operand_valid), 1);
    check("single_out",   32'(operand_out), 32'h5A);
    check("single_count", 32'(count), 1);
    operand_ready = 1'b1; step(); operand_ready = 1'b0;
    check("single_empty_valid", 32'(operand_valid), 0);

    // Inverted load
    load(3'b010, 8'h00, 8'h5A, 8'h00, 1'b1); exp_q.push_back(8'hA5);
    step(); idle();
    check("invert_out", 32'(operand_out), 32'hA5);
    operand_ready = 1'b1; step(); operand_ready = 1'b0;

    // Priority select
    load(3'b110, 8'h00, 8'h11, 8'h22, 1'b0); exp_q.push_back(8'h11);
    step();
    load(3'b111, 8'h33, 8'h11, 8'h22, 1'b0); exp_q.push_back(8'h33);
    step(); idle();
    check("prio_count", 32'(count), 2);
    check("prio_full",  32'(full), 1);
    operand_ready = 1'b1; step(); step(); operand_ready = 1'b0;

    // Fill, then drop a third word
    load(3'b001, 8'h01, 8'h00, 8'h00, 1'b0); exp_q.push_back(8'h01); step();
    load(3'b001, 8'h02, 8'h00, 8'h00, 1'b0); exp_q.push_back(8'h02); step();
    load(3'b001, 8'h03, 8'h00, 8'h00, 1'b0); step();
    idle();
    check("drop_count",    32'(count), 2);
    check("drop_full",     32'(full), 1);
    check("drop_overflow", 32'(overflow), 1);
    load(3'b001, 8'h04, 8'h00, 8'h00, 1'b0); overflow_clr = 1'b1; step();
    idle();
    check("clr_vs_drop_overflow", 32'(overflow), 1);
    step(); overflow_clr = 1'b0;
    check("clr_overflow", 32'(overflow), 0);
    operand_ready = 1'b1; step(); step(); operand_ready = 1'b0;
    check("drain_count", 32'(count), 0);
    check("drain_hold",  32'(operand_out), 32'h02);

    // Full with simultaneous load and pop
    load(3'b001, 8'h01, 8'h00, 8'h00, 1'b0); exp_q.push_back(8'h01); step();
    load(3'b001, 8'h02, 8'h00, 8'h00, 1'b0); exp_q.push_back(8'h02); step();
    load(3'b001, 8'h03, 8'h00, 8'h00, 1'b0); exp_q.push_back(8'h03); operand_ready = 1'b1;
    step(); idle();
    check("fullpop_count",    32'(count), 2);
    check("fullpop_overflow", 32'(overflow), 0);
    step(); step(); operand_ready = 1'b0;
    check("fullpop_drained", 32'(count), 0);

    // Push+pop at count==1: new word becomes head
    load(3'b100, 8'h00, 8'h00, 8'h77, 1'b0); exp_q.push_back(8'h77); step();
    load(3'b100, 8'h00, 8'h00, 8'h88, 1'b0); exp_q.push_back(8'h88); operand_ready = 1'b1;
    step(); idle(); operand_ready = 1'b0;
    check("one_pp_valid", 32'(operand_valid), 1);
    check("one_pp_out",   32'(operand_out), 32'h88);
    check("one_pp_count", 32'(count), 1);
    operand_ready = 1'b1; step(); operand_ready = 1'b0;

    // Hold last popped value; empty pop and idle invert ignored
    load(3'b001, 8'hC3, 8'h00, 8'h00, 1'b0); exp_q.push_back(8'hC3); step(); idle();
    operand_ready = 1'b1; step(); operand_ready = 1'b0;
    check("hold_valid", 32'(operand_valid), 0);
    check("hold_out",   32'(operand_out), 32'hC3);
    operand_ready = 1'b1; invert_en = 1'b1; step(); step(); operand_ready = 1'b0; invert_en = 1'b0;
    check("empty_pop_count", 32'(count), 0);
    check("empty_pop_out",   32'(operand_out), 32'hC3);
    check("empty_pop_ovf",   32'(overflow), 0);

    // Reset mid-operation with two words queued and overflow set
    load(3'b001, 8'h01, 8'h00, 8'h00, 1'b0); step();
    load(3'b001, 8'h02, 8'h00, 8'h00, 1'b0); step();
    load(3'b001, 8'h03, 8'h00, 8'h00, 1'b0); step(); idle();
    check("pre_reset_count", 32'(count), 2);
    #2 rst_n = 1'b0;
    #1 check_reset_state("midreset");
    step(); step();
    #2 rst_n = 1'b1;
    step();
    check("post_reset_valid", 32'(operand_valid), 0);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
